// File: rtl/attn_seq_pkg.sv
// Shared types and inst-word layout for the attention instruction sequencer.
// Field positions mirror fullchip's 17-bit inst input.
package attn_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLOAD,
    S_KTAIL,
    S_GAP1,
    S_EXEC,
    S_GAP2,
    S_DRAIN,
    S_PREAD,
    S_DONE
  } state_t;

  localparam int INST_W    = 17;
  localparam int OFIFO_RD  = 16;
  localparam int QK_ADD_HI = 15;
  localparam int QK_ADD_LO = 12;
  localparam int P_ADD_HI  = 11;
  localparam int P_ADD_LO  = 8;
  localparam int EXEC      = 7;
  localparam int LOAD      = 6;
  localparam int QRD       = 5;
  localparam int QWR       = 4;
  localparam int KRD       = 3;
  localparam int KWR       = 2;
  localparam int PRD       = 1;
  localparam int PWR       = 0;

  localparam int ADD_W = QK_ADD_HI - QK_ADD_LO + 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/attn_seq_inst_enc.sv
// Registered encoder: maps the sequencer's (state, cnt, accept) to fullchip's inst word,
// so inst lags the state register by exactly one cycle.
module attn_seq_inst_enc
  import attn_seq_pkg::*;
#(
  parameter int cnt_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  state_t            state,
  input  logic [cnt_w-1:0]  cnt,
  input  logic              accept,
  output logic [INST_W-1:0] inst
);

  logic [INST_W-1:0] inst_nx;
  logic [ADD_W-1:0]  add;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    inst_nx = '0;
    add     = ADD_W'(cnt);
    case (state)
      S_QWR: if (accept) begin
        inst_nx[QWR]                 = 1'b1;
        inst_nx[QK_ADD_HI:QK_ADD_LO] = add;
      end
      S_KWR: if (accept) begin
        inst_nx[KWR]                 = 1'b1;
        inst_nx[QK_ADD_HI:QK_ADD_LO] = add;
      end
      S_KLOAD: begin
        // kmem has one cycle of read latency, so the address trails the read enable.
        inst_nx[LOAD] = 1'b1;
        inst_nx[KRD]  = (cnt != '0);
        if (cnt >= cnt_w'(2)) inst_nx[QK_ADD_HI:QK_ADD_LO] = add - 1'b1;
      end
      S_KTAIL: inst_nx[LOAD] = 1'b1;
      S_EXEC: begin
        inst_nx[EXEC]                = 1'b1;
        inst_nx[QRD]                 = 1'b1;
        inst_nx[QK_ADD_HI:QK_ADD_LO] = add;
      end
      S_DRAIN: begin
        inst_nx[OFIFO_RD]          = 1'b1;
        inst_nx[PWR]               = 1'b1;
        inst_nx[P_ADD_HI:P_ADD_LO] = add;
      end
      S_PREAD: begin
        inst_nx[PRD]               = 1'b1;
        inst_nx[P_ADD_HI:P_ADD_LO] = add;
      end
      default: inst_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) inst <= '0;
    else       inst <= inst_nx;
  end

endmodule

// File: rtl/attn_inst_sequencer.sv
// Drives fullchip's inst/mem_in through one full Q.K pass per start pulse.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt/stall_cnt performance counters.
module attn_inst_sequencer
  import attn_seq_pkg::*;
#(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int addr_w      = 4,
  parameter int gap         = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [pr*bw-1:0]  host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [INST_W-1:0] inst,
  output logic [pr*bw-1:0]  mem_in,
  output logic              out_valid,
  output logic [addr_w-1:0] out_idx,
  output logic              busy,
  output logic              done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]       cycle_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int MAX_LEN = max_int(max_int(gap, col + 2), total_cycle + 1);
  localparam int CNT_W   = max_int(ADD_W, $clog2(MAX_LEN + 1));

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept, last, pread_hit;

  always_comb begin
    accept = host_ready & host_valid;
    last   = 1'b0;
    case (state)
      S_IDLE:         last = start;
      S_QWR:          last = accept && (cnt == CNT_W'(total_cycle - 1));
      S_KWR:          last = accept && (cnt == CNT_W'(col - 1));
      S_KLOAD:        last = (cnt == CNT_W'(col + 1));
      S_GAP1, S_GAP2: last = (cnt == CNT_W'(gap - 1));
      S_EXEC,
      S_PREAD:        last = (cnt == CNT_W'(total_cycle));
      S_DRAIN:        last = (cnt == CNT_W'(total_cycle - 1));
      default:        last = 1'b1;
    endcase
    state_nx = state;
    if (last) state_nx = (state == S_DONE) ? S_IDLE : state_t'(state + 1'b1);
    pread_hit = (state == S_PREAD) && (cnt != '0);
  end

  // host_ready is registered from the next state so it is valid in the same cycle as accept.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block; all state uses <= only.
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      host_ready <= 1'b0;
      busy       <= 1'b0;
      mem_in     <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == S_IDLE) cnt <= '0;
      else if (state == S_QWR || state == S_KWR) cnt <= cnt + CNT_W'(accept);
      else cnt <= cnt + 1'b1;
      host_ready <= (state_nx == S_QWR) || (state_nx == S_KWR);
      busy       <= (state_nx != S_IDLE);
      if (accept) mem_in <= host_data;
      out_valid <= pread_hit;
      out_idx   <= pread_hit ? addr_w'(cnt - 1'b1) : '0;
      done      <= (state == S_DONE);
    end
  end

  attn_seq_inst_enc #(.cnt_w(CNT_W)) u_enc (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .cnt    (cnt),
    .accept (accept),
    .inst   (inst)
  );

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_acc, stall_acc;

  // cyc_acc counts the start cycle onward; the +2 at DONE covers the DONE cycle and the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_acc   <= '0;
      stall_acc <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cyc_acc   <= 16'd1;
        stall_acc <= '0;
      end else if (state != S_IDLE) begin
        cyc_acc <= sat_add(cyc_acc, 16'd1);
        if (host_ready && !host_valid) stall_acc <= sat_add(stall_acc, 16'd1);
      end
      if (state == S_DONE) begin
        cycle_cnt <= sat_add(cyc_acc, 16'd2);
        stall_cnt <= stall_acc;
      end
    end
  end
`endif

endmodule
